// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command stream into APB transfers
// and reports read data or a timeout abort on a valid/ready response port.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NBYTES         = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NBYTES-1:0]     cmd_strb,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [NBYTES-1:0]     PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // At most one transfer in flight: no accept while a response waits.
    assign cmd_ready = (state == IDLE) && !rsp_valid;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSTRB   <= cmd_write ? cmd_strb : '0;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // Completion takes priority over the timeout.
                    if (PREADY) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 wait_cnt == LAST) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_master;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NB  = DW / 8;
    localparam int TMO = 4;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [NB-1:0] cmd_strb;
    logic          PSELx;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [NB-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int            slave_waits = 0;
    logic [DW-1:0] slave_rdata = '0;

    apb_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NBYTES(NB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb),
        .PSELx(PSELx),
        .PENABLE(PENABLE),
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PSTRB(PSTRB),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: m_acc = 0 is the setup cycle, k >= 1 is the k-th access cycle.
    logic          m_busy;
    int            m_acc;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [NB-1:0] m_strb;
    logic          m_rv;
    logic [DW-1:0] m_rdata;
    logic          m_err;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_busy  <= 1'b0;
            m_acc   <= 0;
            m_addr  <= '0;
            m_write <= 1'b0;
            m_wdata <= '0;
            m_strb  <= '0;
            m_rv    <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            if (m_rv && rsp_ready) m_rv <= 1'b0;
            if (m_busy) begin
                if (m_acc == 0) begin
                    m_acc <= 1;
                end else if (PREADY) begin
                    m_busy  <= 1'b0;
                    m_rv    <= 1'b1;
                    m_err   <= 1'b0;
                    m_rdata <= m_write ? '0 : PRDATA;
                end else if (TMO != 0 && m_acc == TMO) begin
                    m_busy  <= 1'b0;
                    m_rv    <= 1'b1;
                    m_err   <= 1'b1;
                    m_rdata <= '0;
                end else begin
                    m_acc <= m_acc + 1;
                end
            end else if (cmd_valid && !m_rv) begin
                m_busy  <= 1'b1;
                m_acc   <= 0;
                m_addr  <= cmd_addr;
                m_write <= cmd_write;
                m_wdata <= cmd_wdata;
                m_strb  <= cmd_write ? cmd_strb : '0;
            end
        end
    end

    always @(negedge PCLK) begin
        check("cmd_ready", cmd_ready, !m_busy && !m_rv);
        check("PSELx", PSELx, m_busy);
        check("PENABLE", PENABLE, m_busy && m_acc != 0);
        check("PADDR", PADDR, m_addr);
        check("PWRITE", PWRITE, m_write);
        check("PWDATA", PWDATA, m_wdata);
        check("PSTRB", PSTRB, m_strb);
        check("rsp_valid", rsp_valid, m_rv);
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", rsp_err, m_err);
    end

    // Slave: ready on access cycle slave_waits+1; junk outside ACCESS.
    initial begin
        int acc;
        acc    = 0;
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSELx && PENABLE) acc++;
            else acc = 0;
            if (PSELx && PENABLE) begin
                PREADY = (acc == slave_waits + 1);
                PRDATA = slave_rdata;
            end else begin
                PREADY = 1'b1;
                PRDATA = 32'hBAD0_BAD0;
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [NB-1:0] s,
                            output int c0);
        logic took;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        c0 = -1;
        for (int i = 0; i < 50; i++) begin
            took = cmd_ready;
            @(posedge PCLK);
            #1;
            if (took) begin
                c0 = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (c0 < 0) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int lat, output int accs);
        lat  = -1;
        accs = 0;
        for (int i = 1; i < 50; i++) begin
            @(posedge PCLK);
            #1;
            if (PSELx && PENABLE) accs++;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("rsp_wait_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    initial begin
        int c0, lat, accs, gap;
        bit started;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        #2;
        check("rst_psel", PSELx, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        #21 PRESETn = 1'b1;
        idle(2);

        // 1: write, zero wait states
        slave_waits = 0;
        slave_rdata = 32'hCAFE_0001;
        send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, c0);
        check("t1_setup_psel", PSELx, 1);
        check("t1_setup_pen", PENABLE, 0);
        check("t1_paddr", PADDR, 32'h10);
        check("t1_pstrb", PSTRB, 4'hF);
        wait_rsp(lat, accs);
        check("t1_latency", lat, 2);
        check("t1_accs", accs, 1);
        check("t1_rdata", rsp_rdata, 0);
        check("t1_err", rsp_err, 0);
        idle(2);

        // 2: read with two wait states, strobes forced to zero
        slave_waits = 2;
        slave_rdata = 32'h1234_5678;
        send_cmd(1'b0, 32'h20, 32'h55AA_55AA, 4'hA, c0);
        check("t2_pstrb", PSTRB, 0);
        check("t2_pwrite", PWRITE, 0);
        wait_rsp(lat, accs);
        check("t2_accs", accs, 3);
        check("t2_rdata", rsp_rdata, 32'h1234_5678);
        check("t2_err", rsp_err, 0);
        idle(2);

        // 3a: slave never ready -> timeout abort
        slave_waits = 99;
        slave_rdata = 32'h7777_7777;
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0, c0);
        wait_rsp(lat, accs);
        check("t3a_accs", accs, TMO);
        check("t3a_err", rsp_err, 1);
        check("t3a_rdata", rsp_rdata, 0);
        check("t3a_psel", PSELx, 0);
        check("t3a_pen", PENABLE, 0);
        idle(2);

        // 3b: ready on the last allowed access cycle wins
        slave_waits = TMO - 1;
        slave_rdata = 32'h600D_F00D;
        send_cmd(1'b0, 32'h34, 32'h0, 4'h0, c0);
        wait_rsp(lat, accs);
        check("t3b_accs", accs, TMO);
        check("t3b_err", rsp_err, 0);
        check("t3b_rdata", rsp_rdata, 32'h600D_F00D);
        idle(2);

        // 4: response backpressure blocks the next command
        slave_waits = 0;
        slave_rdata = 32'hA5A5_0044;
        rsp_ready   = 1'b0;
        send_cmd(1'b1, 32'h40, 32'h0000_0040, 4'h3, c0);
        wait_rsp(lat, accs);
        cmd_write = 1'b0;
        cmd_addr  = 32'h44;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK);
            #1;
            check("t4_cmd_ready", cmd_ready, 0);
            check("t4_psel", PSELx, 0);
            check("t4_rsp_hold", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        idle(1);
        check("t4_rsp_taken", rsp_valid, 0);
        check("t4_psel_gap", PSELx, 0);
        idle(1);
        check("t4_setup_psel", PSELx, 1);
        check("t4_setup_pen", PENABLE, 0);
        check("t4_paddr", PADDR, 32'h44);
        cmd_valid = 1'b0;
        wait_rsp(lat, accs);
        check("t4_rdata", rsp_rdata, 32'hA5A5_0044);
        idle(2);

        // 5: asynchronous reset in the middle of ACCESS
        slave_waits = 99;
        send_cmd(1'b1, 32'h50, 32'h1111_2222, 4'hC, c0);
        idle(1);
        check("t5_in_access", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("t5_psel", PSELx, 0);
        check("t5_pen", PENABLE, 0);
        check("t5_paddr", PADDR, 0);
        check("t5_pwdata", PWDATA, 0);
        check("t5_pstrb", PSTRB, 0);
        check("t5_pwrite", PWRITE, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK);
            #1;
            check("t5_no_rsp", rsp_valid, 0);
        end
        slave_waits = 1;
        slave_rdata = 32'h0000_5454;
        send_cmd(1'b0, 32'h54, 32'h0, 4'h0, c0);
        wait_rsp(lat, accs);
        check("t5_accs", accs, 2);
        check("t5_rdata", rsp_rdata, 32'h0000_5454);
        idle(2);

        // 6: second command queued right behind the first
        slave_waits = 0;
        send_cmd(1'b1, 32'h60, 32'h0000_0060, 4'hF, c0);
        cmd_write = 1'b1;
        cmd_addr  = 32'h64;
        cmd_wdata = 32'h0000_0064;
        cmd_strb  = 4'h1;
        cmd_valid = 1'b1;
        gap = 0;
        started = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK);
            #1;
            if (!PSELx) begin
                gap++;
            end else if (gap > 0) begin
                started = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("t6_started", started, 1);
        check("t6_gap", gap, 2);
        check("t6_setup_pen", PENABLE, 0);
        check("t6_paddr", PADDR, 32'h64);
        check("t6_pstrb", PSTRB, 4'h1);
        wait_rsp(lat, accs);
        check("t6_err", rsp_err, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

endmodule
